// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle between the core (master) and the mul/div sequencer (slave)
// req_valid/req_ready/op/operand_a/operand_b/flush toward the sequencer; busy/resp_valid/result back to the core
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            resp_valid;
  logic [XLEN-1:0] result;
  modport master (
    output req_valid, op, operand_a, operand_b, flush,
    input  req_ready, busy, resp_valid, result
  );
  modport slave (
    input  req_valid, op, operand_a, operand_b, flush,
    output req_ready, busy, resp_valid, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: bit-serial RV32M multiply/divide unit, one operation per handshake, one bit per cycle
// clk/rst: clock and synchronous active-high reset; bus: slave side of muldiv_sequencer_if
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  muldiv_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t            r_state, w_next;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a, r_b, r_quot, r_result;
  logic [XLEN:0]     r_rem;
  logic [2*XLEN:0]   r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg, r_rem_neg;
  logic              w_hs, w_a_sgn, w_b_sgn, w_neg_a, w_neg_b, w_special, w_ge;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_special_res, w_quot, w_rem, w_fix;
  logic [XLEN:0]     w_sum, w_diff;
  logic [XLEN+1:0]   w_shift;
  logic [2*XLEN-1:0] w_prod;
  assign w_hs    = bus.req_valid & bus.req_ready;
  assign w_a_sgn = (r_op == 3'b001) | (r_op == 3'b010) | (r_op == 3'b100) | (r_op == 3'b110);
  assign w_b_sgn = (r_op == 3'b001) | (r_op == 3'b100) | (r_op == 3'b110);
  assign w_neg_a = w_a_sgn & r_a[XLEN-1];
  assign w_neg_b = w_b_sgn & r_b[XLEN-1];
  assign w_mag_a = w_neg_a ? -r_a : r_a;
  assign w_mag_b = w_neg_b ? -r_b : r_b;
  // Divide by zero and signed -2^(XLEN-1) / -1 skip the iteration entirely
  assign w_special = r_op[2] & ((r_b == '0) | (~r_op[0] & (r_a == {1'b1, {(XLEN-1){1'b0}}}) & (&r_b)));
  assign w_special_res = r_op[1] ? ((r_b == '0) ? r_a : '0) : ((r_b == '0) ? '1 : r_a);
  // Multiply: the extra top accumulator bit keeps the carry of the add before the right shift
  assign w_sum   = r_acc[2*XLEN:XLEN] + {1'b0, r_a};
  // Divide: r_quot starts as the dividend, its MSB feeds the remainder as quotient bits enter at the LSB
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_ge    = w_shift >= {2'b00, r_b};
  assign w_diff  = w_shift[XLEN:0] - {1'b0, r_b};
  assign w_prod  = r_neg ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
  assign w_quot  = r_neg ? -r_quot : r_quot;
  assign w_rem   = r_rem_neg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
  assign w_fix   = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                           : ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = bus.flush            ? IDLE :
             (r_state == IDLE)    ? (w_hs ? PREP : IDLE) :
             (r_state == PREP)    ? (w_special ? DONE : ITER) :
             (r_state == ITER)    ? ((r_cnt == '0) ? FIX : ITER) :
             (r_state == FIX)     ? DONE : IDLE;
  end
  always_comb begin
    bus.req_ready  = (r_state == IDLE) & ~bus.flush & ~rst;
    bus.busy       = r_state != IDLE;
    bus.resp_valid = r_state == DONE;
  end
  assign bus.result = r_result;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_hs) begin
        r_op <= bus.op;
        r_a  <= bus.operand_a;
        r_b  <= bus.operand_b;
      end
      if (r_state == PREP) begin
        r_neg     <= w_neg_a ^ w_neg_b;
        r_rem_neg <= w_neg_a;
        r_a       <= w_mag_a;
        r_b       <= w_mag_b;
        r_acc     <= {{(XLEN+1){1'b0}}, w_mag_b};
        r_rem     <= '0;
        r_quot    <= w_mag_a;
        r_cnt     <= CNT_W'(XLEN-1);
        if (w_special & ~bus.flush) r_result <= w_special_res;
      end
      if (r_state == ITER) begin
        r_acc  <= {1'b0, (r_acc[0] ? w_sum : r_acc[2*XLEN:XLEN]), r_acc[XLEN-1:1]};
        r_rem  <= w_ge ? w_diff : w_shift[XLEN:0];
        r_quot <= {r_quot[XLEN-2:0], w_ge};
        r_cnt  <= r_cnt - 1'b1;
      end
      if ((r_state == FIX) & ~bus.flush) r_result <= w_fix;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer covering results, latency, flush, reset and back-to-back issue
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;
  muldiv_sequencer_if #(.XLEN(32)) bus();
  muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'b0, a};
    longint ub = {32'b0, b};
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction
  task automatic send(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int waited);
    bus.req_valid = 1'b1;
    bus.op = o;
    bus.operand_a = a;
    bus.operand_b = b;
    waited = 0;
    while (!bus.req_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_resp(output logic [31:0] res, output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
  endtask
  task automatic exec(input vec_t v, output logic [31:0] res, output int lat, output int waited);
    exp_q.push_back(v.e);
    send(v.op, v.a, v.b, waited);
    wait_resp(res, lat);
  endtask
  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    bus.op = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b want=0", bus.resp_valid); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.req_ready); end
    rst = 1'b0;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", bus.req_ready); end
  endtask
  task automatic test_mul();
    vec_t v[4];
    logic [31:0] res, exp;
    int lat, w;
    v[0] = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    v[1] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[2] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    foreach (v[i]) begin
      exec(v[i], res, lat, w);
      exp = exp_q.pop_front();
      total++; if (res !== exp) begin bad++; $display("FAIL mul[%0d] result got=%h want=%h", i, res, exp); end
      total++; if (lat !== 35) begin bad++; $display("FAIL mul[%0d] latency got=%0d want=35", i, lat); end
    end
  endtask
  task automatic test_div();
    vec_t v[4];
    logic [31:0] res, exp;
    int lat, w;
    v[0] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    v[1] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    v[2] = '{3'd5, 32'd100, 32'd7, 32'd14};
    v[3] = '{3'd7, 32'd100, 32'd7, 32'd2};
    foreach (v[i]) begin
      exec(v[i], res, lat, w);
      exp = exp_q.pop_front();
      total++; if (res !== exp) begin bad++; $display("FAIL div[%0d] result got=%h want=%h", i, res, exp); end
      total++; if (lat !== 35) begin bad++; $display("FAIL div[%0d] latency got=%0d want=35", i, lat); end
    end
  endtask
  task automatic test_special();
    vec_t v[6];
    logic [31:0] res, exp;
    int lat, w;
    v[0] = '{3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF};
    v[1] = '{3'd6, 32'd5, 32'd0, 32'd5};
    v[2] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[3] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    v[4] = '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF};
    v[5] = '{3'd7, 32'd9, 32'd0, 32'd9};
    foreach (v[i]) begin
      exec(v[i], res, lat, w);
      exp = exp_q.pop_front();
      total++; if (res !== exp) begin bad++; $display("FAIL special[%0d] result got=%h want=%h", i, res, exp); end
      total++; if (lat !== 2) begin bad++; $display("FAIL special[%0d] latency got=%0d want=2", i, lat); end
    end
  endtask
  task automatic test_flush();
    logic [31:0] held;
    int w;
    int pulses = 0;
    held = bus.result;
    send(3'd5, 32'd100, 32'd7, w);
    repeat (9) begin
      @(posedge clk); #1;
      if (bus.resp_valid) pulses++;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", bus.req_ready); end
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.resp_valid) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL flush_resp pulses got=%0d want=0", pulses); end
    total++; if (bus.result !== held) begin bad++; $display("FAIL flush_result got=%h want=%h", bus.result, held); end
    bus.flush = 1'b1;
    bus.req_valid = 1'b1;
    bus.op = 3'd0;
    #1;
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL flush_req_ready got=%b want=0", bus.req_ready); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_req_busy got=%b want=0", bus.busy); end
  endtask
  task automatic test_rst_mid();
    int w;
    int pulses = 0;
    send(3'd2, 32'hFFFF_FFFF, 32'h1234_5678, w);
    repeat (19) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy_before got=%b want=1", bus.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", bus.busy); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", bus.result); end
    total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", bus.req_ready); end
    rst = 1'b0;
    #1;
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready_after got=%b want=1", bus.req_ready); end
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.resp_valid) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL rst_mid_resp pulses got=%0d want=0", pulses); end
  endtask
  task automatic test_back_to_back();
    vec_t v;
    logic [31:0] res, exp;
    int lat, w, want_lat;
    for (int i = 0; i < 12; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.a = $urandom;
      v.b = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 3) v.b = 32'h0;
      if (i == 5) begin v.op = 3'd4; v.a = 32'h8000_0000; v.b = 32'hFFFF_FFFF; end
      if (i == 7) begin v.op = 3'd6; v.a = 32'h8000_0007; v.b = 32'd3; end
      v.e = model(v.op, v.a, v.b);
      want_lat = (v.op[2] && (v.b == 0 || (!v.op[0] && v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF))) ? 2 : 35;
      exec(v, res, lat, w);
      exp = exp_q.pop_front();
      total++; if (res !== exp) begin bad++; $display("FAIL b2b[%0d] op=%0d a=%h b=%h got=%h want=%h", i, v.op, v.a, v.b, res, exp); end
      total++; if (lat !== want_lat) begin bad++; $display("FAIL b2b[%0d] latency got=%0d want=%0d", i, lat, want_lat); end
      if (i > 0) begin
        total++; if (w !== 1) begin bad++; $display("FAIL b2b[%0d] accept_wait got=%0d want=1", i, w); end
      end
    end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
